ysyx_041461_mem_access: RTL
===========================

// Module: ysyx_041461_mem_access
// PURPOSE
//  MEM-stage memory access unit; producer side of the WB pipeline register.
//  - Takes load/store ops from the MEM stage and runs a req/resp transaction on the data-memory bus.
//  - Produces the loaded value, valid flag and trap code that feed the WB register inputs.
//  - Produces the stall that gates the pipeline enable while a transaction is outstanding.
// PARAMETERS
//  XLEN    64  data/address width; byte lanes = XLEN/8 = 8
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     asynchronous reset, active-low
//  in_valid        in   1     MEM-stage op valid
//  in_ctrl         in   5     {is_store, is_load, unsigned, size[1:0]}; size 0=B 1=H 2=W 3=D
//  in_addr         in   XLEN  effective address (EXE result)
//  in_wdata        in   XLEN  store data, LSB-aligned
//  wb_enable       in   1     WB register captures this cycle
//  bus_req_valid   out  1     bus request valid
//  bus_req_ready   in   1     bus accepts request
//  bus_req_wen     out  1     1 = write
//  bus_req_addr    out  XLEN  address, addr[2:0] forced to 0
//  bus_req_wdata   out  XLEN  lane-shifted store data
//  bus_req_wmask   out  8     byte-lane strobe
//  bus_resp_valid  in   1     response valid (one per request)
//  bus_resp_rdata  in   XLEN  read data, 8-byte aligned
//  mem_valid_out   out  1     to WBreg_valid_fromMEM
//  mem_data_out    out  XLEN  load result, extended; 0 for non-loads
//  mem_trap_out    out  4     0=none, 1=load misaligned, 2=store misaligned
//  mem_stall       out  1     1 = hold upstream stages, deassert pipeline enable
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; all captured registers 0.
//    bus_req_valid=0, mem_valid_out=0, mem_data_out=0, mem_trap_out=0, mem_stall=0.
//  - access = in_valid & (is_load | is_store). is_load & is_store together = treated as store.
//  - aligned = (addr mod 2^size)==0. Combinational; only used in IDLE.
//  - States: IDLE, REQ, WAIT, DONE.
//  - IDLE
//    - Non-access op: mem_valid_out=in_valid, mem_data_out=0, trap=0, stall=0 (0-cycle pass-through).
//    - access & !aligned: no bus request; mem_valid_out=1, trap=1 (load) or 2 (store), data=0, stall=0.
//    - access & aligned: capture addr/ctrl/wdata; go to REQ; mem_valid_out=0, stall=1.
//  - REQ
//    - bus_req_valid=1; addr/wen/wdata/wmask come from captured values and are stable until accepted.
//    - On bus_req_ready: go to WAIT.
//    - A response in the same cycle as ready is not accepted; the bus returns it no earlier than the next cycle.
//  - WAIT
//    - bus_req_valid=0.
//    - On bus_resp_valid: register result, go to DONE.
//      - Load: rdata >> (8*addr[2:0]); low (8<<size) bits; sign- or zero-extended per unsigned.
//      - Store: result = 0.
//  - DONE
//    - mem_valid_out=1, mem_data_out=registered result, trap=0.
//    - stall = !wb_enable. On wb_enable, go to IDLE.
//    - Back-to-back accesses therefore cost 1 idle cycle.
//  - Stall: stall=1 in REQ and WAIT, and in IDLE on an aligned access.
//  - Store encoding
//    - wmask = ((1<<(1<<size))-1) << addr[2:0].
//    - wdata = in_wdata << (8*addr[2:0]).
//  - While stalled, in_* are ignored; the captured copy is authoritative.
//  - bus_resp_valid outside WAIT is ignored.
//  - Reset mid-transaction: back to IDLE, request dropped; a late response is ignored in IDLE.
//  - Latency, aligned access with 0-wait bus: 1 cycle REQ + 1 cycle WAIT, then result in DONE.
//    Stall covers 3 cycles when wb_enable=1.
// TESTING
//  - Reset: rst=0 mid-WAIT -> next edge: all outputs 0, state IDLE; a following resp_valid does not set mem_valid_out.
//  - LB signed: addr=0x...1003, rdata=0x0000_0000_8000_0000 -> mem_data_out=0xFFFF_FFFF_FFFF_FF80.
//    LBU on the same data -> 0x80.
//  - SH: addr=0x...2006, wdata=0x1234 -> wmask=0xC0, bus_req_wdata[63:48]=0x1234, wen=1.
//    mem_data_out=0 in DONE.
//  - Misaligned LW at addr 0x...0002 -> no bus_req_valid, same-cycle mem_valid_out=1, mem_trap_out=1, stall=0.
//  - Backpressure: bus_req_ready low 5 cycles then high, resp 3 cycles later.
//    -> req payload stable all 5 cycles; stall high throughout; DONE once.
//  - wb_enable=0 for 2 cycles in DONE -> mem_valid_out and data held, stall=1; released on wb_enable=1.

Source files
------------

// File: rtl/ysyx_041461_mem_access.sv
// MEM-stage memory access unit: runs one req/resp data-bus transaction per
// aligned load/store and hands the extended result, valid flag and trap code
// to the WB pipeline register. Misaligned and non-memory ops pass through
// in the same cycle without touching the bus.
module ysyx_041461_mem_access #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [4:0]      in_ctrl,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic            wb_enable,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic            bus_req_wen,
    output logic [XLEN-1:0] bus_req_addr,
    output logic [XLEN-1:0] bus_req_wdata,
    output logic [7:0]      bus_req_wmask,
    input  logic            bus_resp_valid,
    input  logic [XLEN-1:0] bus_resp_rdata,
    output logic            mem_valid_out,
    output logic [XLEN-1:0] mem_data_out,
    output logic [3:0]      mem_trap_out,
    output logic            mem_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] TRAP_NONE     = 4'd0;
    localparam logic [3:0] TRAP_LD_MISAL = 4'd1;
    localparam logic [3:0] TRAP_ST_MISAL = 4'd2;

    state_t            state_r;
    logic [XLEN-1:0]   bus_addr_r;
    logic [XLEN-1:0]   bus_wdata_r;
    logic [7:0]        bus_wmask_r;
    logic              bus_wen_r;
    logic [2:0]        off_r;
    logic [2:0]        ctrl_r;       // {unsigned, size[1:0]} of the captured op
    logic [XLEN-1:0]   result_r;

    logic              is_store_s;
    logic              is_load_s;
    logic              access_s;
    logic              aligned_s;

    logic              valid_s;
    logic [XLEN-1:0]   data_s;
    logic [3:0]        trap_s;
    logic              stall_s;

    // Natural alignment check: offset must be a multiple of the access size.
    function automatic logic is_aligned(input logic [2:0] off, input logic [1:0] size);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (off[0] == 1'b0);
            2'd2:    ok = (off[1:0] == 2'b00);
            2'd3:    ok = (off == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane strobe for an access of 2^size bytes starting at lane off.
    function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01 << off;
            2'd1:    m = 8'h03 << off;
            2'd2:    m = 8'h0F << off;
            2'd3:    m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    // Pull the addressed field out of an aligned bus word and extend it.
    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                     input logic [2:0]      off,
                                                     input logic [2:0]      ctrl);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = rdata >> {off, 3'b000};
        case (ctrl[1:0])
            2'd0:    r = ctrl[2] ? {{(XLEN-8){1'b0}}, sh[7:0]}
                                 : {{(XLEN-8){sh[7]}}, sh[7:0]};
            2'd1:    r = ctrl[2] ? {{(XLEN-16){1'b0}}, sh[15:0]}
                                 : {{(XLEN-16){sh[15]}}, sh[15:0]};
            2'd2:    r = ctrl[2] ? {{(XLEN-32){1'b0}}, sh[31:0]}
                                 : {{(XLEN-32){sh[31]}}, sh[31:0]};
            2'd3:    r = sh;
            default: r = sh;
        endcase
        return r;
    endfunction

    assign is_store_s = in_ctrl[4];
    assign is_load_s  = in_ctrl[3];
    assign access_s   = in_valid & (is_store_s | is_load_s);
    assign aligned_s  = is_aligned(in_addr[2:0], in_ctrl[1:0]);

    // Transaction sequencer: captures the op, drives the bus handshake, holds the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            bus_addr_r  <= {XLEN{1'b0}};
            bus_wdata_r <= {XLEN{1'b0}};
            bus_wmask_r <= 8'h00;
            bus_wen_r   <= 1'b0;
            off_r       <= 3'd0;
            ctrl_r      <= 3'd0;
            result_r    <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (access_s && aligned_s) begin
                        bus_addr_r  <= {in_addr[XLEN-1:3], 3'b000};
                        bus_wdata_r <= in_wdata << {in_addr[2:0], 3'b000};
                        bus_wmask_r <= lane_mask(in_addr[2:0], in_ctrl[1:0]);
                        bus_wen_r   <= is_store_s;
                        off_r       <= in_addr[2:0];
                        ctrl_r      <= in_ctrl[2:0];
                        result_r    <= {XLEN{1'b0}};
                        state_r     <= REQ;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    if (bus_resp_valid) begin
                        result_r <= bus_wen_r ? {XLEN{1'b0}}
                                              : load_extract(bus_resp_rdata, off_r, ctrl_r);
                        state_r  <= DONE;
                    end else begin
                        state_r  <= WAIT;
                    end
                end
                DONE: begin
                    if (wb_enable) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // WB-side outputs: same-cycle pass-through in IDLE, held result in DONE.
    always_comb begin
        valid_s = 1'b0;
        data_s  = {XLEN{1'b0}};
        trap_s  = TRAP_NONE;
        stall_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    if (aligned_s) begin
                        stall_s = 1'b1;
                    end else begin
                        valid_s = 1'b1;
                        trap_s  = is_store_s ? TRAP_ST_MISAL : TRAP_LD_MISAL;
                    end
                end else begin
                    valid_s = in_valid;
                end
            end
            REQ:  stall_s = 1'b1;
            WAIT: stall_s = 1'b1;
            DONE: begin
                valid_s = 1'b1;
                data_s  = result_r;
                stall_s = ~wb_enable;
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    assign bus_req_valid = (state_r == REQ);
    assign bus_req_wen   = bus_wen_r;
    assign bus_req_addr  = bus_addr_r;
    assign bus_req_wdata = bus_wdata_r;
    assign bus_req_wmask = bus_wmask_r;

    assign mem_valid_out = valid_s;
    assign mem_data_out  = data_s;
    assign mem_trap_out  = trap_s;
    assign mem_stall     = stall_s;

endmodule
